rng_share_ctrl: RTL and testbench
=================================

// Module: rng_share_ctrl
// PURPOSE
//  Shares one 16-bit XOR-feedback random generator among NUM_REQ requesters (e.g. enemy/tile placement engines).
//  Owns the generator state: loads and sanitises seeds, runs a discard warm-up, then hands one word per cycle to requesters.
//  Requesters are served round-robin. The word is delivered with a one-cycle grant pulse.
// PARAMETERS
//  NUM_REQ       4        number of requesters (2..8)
//  WARMUP        4        generator steps discarded after reset/seed load (0..255)
//  DEFAULT_SEED  16'hACE1 seed used at reset and in place of any zero seed
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  seed_load  in   1        1-cycle pulse: load seed_in into the generator
//  seed_in    in   16       seed value, sampled when seed_load=1
//  req        in   NUM_REQ  per-requester level request
//  gnt        out  NUM_REQ  one-hot grant pulse; rnd_out is valid for that requester
//  rnd_out    out  16       random word, valid when |gnt
//  ready      out  1        1 in S_RUN (requests may be served)
//  lockup     out  1        sticky: generator state was found to be 0 and was recovered
// BEHAVIOUR
//  Next-state function f(d), with n = f(d):
//   - n[15] = d[15]^d[1]
//   - n[14] = d[14]^d[0]
//   - n[k]  = d[k]^n[k+2] for k = 13 down to 0
//   - f(0) = 0, so a zero state is a lock-up state and is never allowed.
//  Reset (async, rst=1):
//   - state = DEFAULT_SEED, fsm = S_WARM, warm_cnt = WARMUP
//   - gnt = 0, rnd_out = 0, ready = 0, lockup = 0, rr_ptr = 0
//  FSM states: S_WARM, S_RUN.
//   - S_WARM: state <= f(state) each cycle; warm_cnt decrements. At warm_cnt==0 go to S_RUN (WARMUP=0 means 0 steps).
//     Requests are ignored; gnt = 0.
//   - S_RUN: the cycle after reaching this state, ready=1.
//     If |req at cycle t, winner w = first asserted index at or after rr_ptr (wrapping mod NUM_REQ).
//     At t+1: gnt[w]=1 and rnd_out = state(t); state <= f(state(t)); rr_ptr <= (w+1) mod NUM_REQ.
//     Latency is req -> gnt in 1 cycle; throughput is one grant per cycle.
//     A requester holding req high is re-served only after the other active requesters have been served.
//     With no req, state holds (no advance), gnt = 0, rnd_out holds its last value.
//   - Requesters drop req in the cycle gnt is seen. A req still high in the cycle gnt is seen is a new request.
//  seed_load (any state, priority over everything):
//   - next cycle state = (seed_in==0 ? DEFAULT_SEED : seed_in); fsm = S_WARM; warm_cnt = WARMUP; ready = 0; gnt = 0.
//   - A grant decision in the same cycle is dropped; the requester keeps req and is served after warm-up.
//   - rr_ptr is kept.
//  Lock-up guard: if state==0 is ever observed in S_RUN, the cycle's grant is suppressed, state <= DEFAULT_SEED and lockup <= 1.
//   The flag is cleared only by rst.
//  Reset mid-operation: immediate return to the reset values; an in-flight grant is lost.
//  Widths: warm_cnt is 8 bits. rr_ptr is $clog2(NUM_REQ) bits and wraps at NUM_REQ-1 -> 0 (NUM_REQ need not be a power of 2).
// STRUCTURE
//  Shared package rng_pkg:
//   - RNG_W = 16, DEFAULT_SEED, the FSM state typedef (S_WARM, S_RUN)
//   - function rng_next(d) implementing f
//  Sub-module rng_rr_arbiter (combinational):
//   - inputs req and rr_ptr; outputs one-hot win and win_idx
//   - reusable for other shared resources
//  Top module: generator state register, FSM, warm-up counter, pointer update, output registers.
// TESTING
//  1. Release rst, WARMUP=0, seed_load seed_in=16'h0001, then req=4'b0001.
//     -> gnt=0001 with rnd_out=16'h0001, then 16'h5554 on the next grant.
//  2. req=4'b1111 held, 8 cycles in S_RUN.
//     -> gnt sequence 0001,0010,0100,1000,0001,...; each rnd_out equals f of the previous one.
//  3. seed_load with seed_in=16'h0000.
//     -> generator is loaded with 16'hACE1; lockup stays 0; ready low for WARMUP+1 cycles.
//  4. seed_load in the same cycle as req=4'b0100.
//     -> no gnt that cycle; gnt=0100 arrives on the first S_RUN cycle after warm-up.
//  5. Default WARMUP=4 after rst.
//     -> first rnd_out = f^4(16'hACE1); rst pulsed mid-stream restores that exact sequence.
//  6. Force the state register to 0 in S_RUN.
//     -> no gnt that cycle; lockup=1 (sticky); next rnd_out = 16'hACE1.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared definitions for the round-robin random-word distributor:
// generator width, default seed, controller states and the generator step.
package rng_pkg;

    localparam int RNG_W = 16;
    localparam logic [RNG_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic {
        S_WARM = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    // Two-bit XOR-feedback step; the low bits fold in already-updated high bits.
    function automatic logic [RNG_W-1:0] rng_next(input logic [RNG_W-1:0] d);
        logic [RNG_W-1:0] n;
        n      = '0;
        n[15]  = d[15] ^ d[1];
        n[14]  = d[14] ^ d[0];
        for (int k = 13; k >= 0; k--) begin
            n[k] = d[k] ^ n[k+2];
        end
        return n;
    endfunction

endpackage

// File: rtl/rng_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after rr_ptr, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
module rng_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx
);

    int w_dist;
    int w_best;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        win     = '0;
        win_idx = '0;
        w_dist  = 0;
        w_best  = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = j - int'(rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                win_idx = PTR_W'(j);
            end
        end
        if (w_best < NUM_REQ) begin
            win[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rng_share_ctrl.sv
// Owns one 16-bit random generator, runs a discard warm-up after reset or seed
// load, then hands one word per cycle to requesters in round-robin order.
module rng_share_ctrl #(
    parameter int          NUM_REQ      = 4,
    parameter int          WARMUP       = 4,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [15:0]        seed_in,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [15:0]        rnd_out,
    output logic               ready,
    output logic               lockup
);

    import rng_pkg::*;

    localparam int               PTR_W     = $clog2(NUM_REQ);
    localparam logic [7:0]       WARM_INIT = 8'(WARMUP);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    fsm_t               r_fsm;
    logic [RNG_W-1:0]   r_state;
    logic [7:0]         r_warm_cnt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [RNG_W-1:0]   r_rnd;
    logic               r_lockup;

    fsm_t               w_fsm_nxt;
    logic [RNG_W-1:0]   w_state_nxt;
    logic [7:0]         w_warm_cnt_nxt;
    logic [PTR_W-1:0]   w_rr_ptr_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [RNG_W-1:0]   w_rnd_nxt;
    logic               w_lockup_nxt;
    logic [NUM_REQ-1:0] w_win;
    logic [PTR_W-1:0]   w_win_idx;

    rng_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .win     (w_win),
        .win_idx (w_win_idx)
    );

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_state_nxt    = r_state;
        w_warm_cnt_nxt = r_warm_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_gnt_nxt      = '0;
        w_rnd_nxt      = r_rnd;
        w_lockup_nxt   = r_lockup;
        if (seed_load) begin
            // A zero seed would lock the generator, so it is replaced.
            w_state_nxt    = (seed_in == '0) ? DEFAULT_SEED : seed_in;
            w_fsm_nxt      = S_WARM;
            w_warm_cnt_nxt = WARM_INIT;
        end else begin
            case (r_fsm)
                S_WARM: begin
                    if (r_warm_cnt == 8'd0) begin
                        w_fsm_nxt = S_RUN;
                    end else begin
                        w_state_nxt    = rng_next(r_state);
                        w_warm_cnt_nxt = r_warm_cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    if (r_state == '0) begin
                        w_state_nxt  = DEFAULT_SEED;
                        w_lockup_nxt = 1'b1;
                    end else if (|req) begin
                        w_gnt_nxt    = w_win;
                        w_rnd_nxt    = r_state;
                        w_state_nxt  = rng_next(r_state);
                        w_rr_ptr_nxt = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + PTR_W'(1);
                    end
                end
                default: w_fsm_nxt = S_WARM;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= S_WARM;
            r_state    <= DEFAULT_SEED;
            r_warm_cnt <= WARM_INIT;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_rnd      <= '0;
            r_lockup   <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rnd      <= w_rnd_nxt;
            r_lockup   <= w_lockup_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign rnd_out = r_rnd;
    assign ready   = (r_fsm == S_RUN);
    assign lockup  = r_lockup;

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench: instance u_a runs with no warm-up, u_b with the default
// warm-up of 4; outputs are sampled on the falling edge.
module tb_rng_share_ctrl;

    logic        clk;
    logic        a_rst, a_seed_load, b_rst, b_seed_load;
    logic [15:0] a_seed_in, b_seed_in, a_rnd, b_rnd;
    logic [3:0]  a_req, b_req, a_gnt, b_gnt;
    logic        a_ready, a_lockup, b_ready, b_lockup;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_r;
    int          cycles;

    rng_share_ctrl #(.NUM_REQ(4), .WARMUP(0), .DEFAULT_SEED(16'hACE1)) u_a (
        .clk(clk), .rst(a_rst), .seed_load(a_seed_load), .seed_in(a_seed_in),
        .req(a_req), .gnt(a_gnt), .rnd_out(a_rnd), .ready(a_ready), .lockup(a_lockup)
    );

    rng_share_ctrl #(.NUM_REQ(4), .WARMUP(4), .DEFAULT_SEED(16'hACE1)) u_b (
        .clk(clk), .rst(b_rst), .seed_load(b_seed_load), .seed_in(b_seed_in),
        .req(b_req), .gnt(b_gnt), .rnd_out(b_rnd), .ready(b_ready), .lockup(b_lockup)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] f_ref(input logic [15:0] d);
        logic [15:0] n;
        n     = '0;
        n[15] = d[15] ^ d[1];
        n[14] = d[14] ^ d[0];
        for (int k = 13; k >= 0; k--) n[k] = d[k] ^ n[k+2];
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_seed_load = 1'b0; a_seed_in = '0; a_req = '0;
        b_rst = 1'b1; b_seed_load = 1'b0; b_seed_in = '0; b_req = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("a_rst_gnt", a_gnt, 0);
        check("a_rst_rnd", a_rnd, 0);
        check("a_rst_ready", a_ready, 0);
        check("a_rst_lockup", a_lockup, 0);
        check("b_rst_gnt", b_gnt, 0);
        check("b_rst_ready", b_ready, 0);

        // 1. Seed 0x0001 with no warm-up, single requester
        a_rst = 1'b0; b_rst = 1'b0;
        a_seed_load = 1'b1; a_seed_in = 16'h0001;
        @(negedge clk);
        a_seed_load = 1'b0;
        check("t1_ready_low", a_ready, 0);
        @(negedge clk);
        check("t1_ready_high", a_ready, 1);
        a_req = 4'b0001;
        @(negedge clk);
        check("t1_gnt0", a_gnt, 4'b0001);
        check("t1_rnd0", a_rnd, 16'h0001);
        @(negedge clk);
        check("t1_gnt1", a_gnt, 4'b0001);
        check("t1_rnd1", a_rnd, 16'h5554);
        a_req = 4'b0000;
        @(negedge clk);
        check("t1_idle_gnt", a_gnt, 0);
        check("t1_idle_hold", a_rnd, 16'h5554);
        @(negedge clk);
        exp_r = 16'h5554;

        // 2. All four requesting; pointer sits at 1 after two grants to requester 0
        a_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_r = f_ref(exp_r);
            check($sformatf("t2_gnt%0d", i), a_gnt, 4'b0001 << ((i + 1) % 4));
            check($sformatf("t2_rnd%0d", i), a_rnd, exp_r);
        end
        a_req = 4'b0000;
        @(negedge clk);
        check("t2_idle_gnt", a_gnt, 0);

        // 3. Zero seed is replaced by the default seed
        a_seed_load = 1'b1; a_seed_in = 16'h0000;
        @(negedge clk);
        a_seed_load = 1'b0;
        check("t3_ready_low", a_ready, 0);
        check("t3_lockup", a_lockup, 0);
        @(negedge clk);
        check("t3_ready_high", a_ready, 1);
        a_req = 4'b0001;
        @(negedge clk);
        check("t3_gnt", a_gnt, 4'b0001);
        check("t3_rnd", a_rnd, 16'hACE1);
        a_req = 4'b0000;
        @(negedge clk);

        // 4. seed_load collides with a request; the request is served after warm-up
        a_seed_load = 1'b1; a_seed_in = 16'h1234; a_req = 4'b0100;
        @(negedge clk);
        a_seed_load = 1'b0;
        check("t4_dropped_gnt", a_gnt, 0);
        check("t4_ready_low", a_ready, 0);
        @(negedge clk);
        check("t4_warm_gnt", a_gnt, 0);
        check("t4_ready_high", a_ready, 1);
        @(negedge clk);
        check("t4_gnt", a_gnt, 4'b0100);
        check("t4_rnd", a_rnd, 16'h1234);
        a_req = 4'b0000;
        @(negedge clk);

        // 6. Zero generator state in S_RUN triggers the lock-up guard
        force u_a.r_state = 16'h0000;
        a_req = 4'b0001;
        #1 release u_a.r_state;
        @(negedge clk);
        check("t6_suppressed_gnt", a_gnt, 0);
        check("t6_lockup", a_lockup, 1);
        @(negedge clk);
        check("t6_gnt", a_gnt, 4'b0001);
        check("t6_rnd", a_rnd, 16'hACE1);
        a_req = 4'b0000;
        a_seed_load = 1'b1; a_seed_in = 16'h0002;
        @(negedge clk);
        a_seed_load = 1'b0;
        check("t6_lockup_sticky", a_lockup, 1);

        // 5. Default warm-up of 4 discards four steps of 0xACE1
        exp_r = 16'hACE1;
        for (int i = 0; i < 4; i++) exp_r = f_ref(exp_r);
        check("t5_ready", b_ready, 1);
        b_req = 4'b0010;
        @(negedge clk);
        check("t5_gnt0", b_gnt, 4'b0010);
        check("t5_rnd0", b_rnd, exp_r);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            exp_r = f_ref(exp_r);
            check($sformatf("t5_rnd%0d", i), b_rnd, exp_r);
        end
        b_rst = 1'b1;
        #1;
        check("t5_midrst_gnt", b_gnt, 0);
        check("t5_midrst_rnd", b_rnd, 0);
        check("t5_midrst_ready", b_ready, 0);
        @(negedge clk);
        b_rst = 1'b0;
        cycles = 0;
        while (!b_ready && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("t5_warm_cycles", cycles, 5);
        @(negedge clk);
        exp_r = 16'hACE1;
        for (int i = 0; i < 4; i++) exp_r = f_ref(exp_r);
        check("t5_rst_gnt", b_gnt, 4'b0010);
        check("t5_rst_rnd", b_rnd, exp_r);
        b_req = 4'b0000;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
